// File: rtl/m_decode_stage.sv
// m_decode_stage: registered IF->ID decode stage of an RV32I pipeline with a 2-entry skid buffer.
//   Ports: w_clk, w_rst_n (sync, active-low), w_flush (drop all entries);
//          in_valid/in_ready/in_ir/in_pc  upstream handshake and instruction;
//          out_valid/out_ready            downstream handshake;
//          out_ir/out_pc                  passthrough; out_rd/out_rs1/out_rs2 register indices;
//          out_imm                        sign-extended immediate; out_r..out_j one-hot format;
//          out_illegal                    illegal-encoding flag, active only with DECODE_ILLEGAL_EN defined.
module m_decode_stage #(
    parameter int PC_W = 32
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic            w_flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic            out_r,
    output logic            out_i,
    output logic            out_s,
    output logic            out_b,
    output logic            out_u,
    output logic            out_j,
    output logic            out_illegal
);
    localparam int EW = 7 + 32 + PC_W + 32;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t         state, state_nx;
    logic [EW-1:0]  main_q, skid_q, dec;
    logic [4:0]     op;
    logic           t_r, t_i, t_s, t_b, t_u, t_j, illegal;
    logic [31:0]    imm;
    logic           acc, ret, ld_main_new, ld_main_skid, ld_skid;

    assign op  = in_ir[6:2];
    assign t_r = op == 5'b01100;
    assign t_s = op == 5'b01000;
    assign t_b = op == 5'b11000;
    assign t_u = op == 5'b00101 || op == 5'b01101;
    assign t_j = op == 5'b11011;
    assign t_i = ~(t_r | t_s | t_b | t_u | t_j);

    assign imm = t_i ? {{20{in_ir[31]}}, in_ir[31:20]} :
                 t_s ? {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]} :
                 t_b ? {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0} :
                 t_u ? {in_ir[31:12], 12'b0} :
                 t_j ? {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0} :
                       32'd0;

`ifdef DECODE_ILLEGAL_EN
    assign illegal = in_ir[1:0] != 2'b11 ||
                     !(op inside {5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11001,
                                  5'b11011, 5'b00101, 5'b01101, 5'b11100, 5'b00011});
`else
    assign illegal = 1'b0;
`endif

    assign dec = {illegal, t_r, t_i, t_s, t_b, t_u, t_j, imm, in_pc, in_ir};

    // in_ready depends only on the state register, so out_ready never reaches in_ready combinationally.
    always_comb begin
        state_nx     = state;
        ld_main_new  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        in_ready     = state != TWO;
        out_valid    = state != EMPTY;
        acc          = in_valid & in_ready;
        ret          = out_valid & out_ready;
        case (state)
            EMPTY: if (acc) begin
                state_nx    = ONE;
                ld_main_new = 1'b1;
            end
            ONE: if (acc) begin
                state_nx    = ret ? ONE : TWO;
                ld_main_new = ret;
                ld_skid     = ~ret;
            end else if (ret) begin
                state_nx = EMPTY;
            end
            TWO: if (ret) begin
                state_nx     = ONE;
                ld_main_skid = 1'b1;
            end
            default: state_nx = EMPTY;
        endcase
        if (w_flush) begin
            state_nx     = EMPTY;
            ld_main_new  = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge w_clk)
        state <= !w_rst_n ? EMPTY : state_nx;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_new)
                main_q <= dec;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= dec;
        end
    end

    assign {out_illegal, out_r, out_i, out_s, out_b, out_u, out_j, out_imm, out_pc, out_ir} = main_q;
    assign out_rd  = out_ir[11:7];
    assign out_rs1 = out_ir[19:15];
    assign out_rs2 = out_ir[24:20];
endmodule
